// File: rtl/axis_frame_rr_arbiter_pkg.sv
// Shared types for the frame round-robin arbiter: FSM encoding and the
// beat record that travels through the output register slice.
package axis_frame_rr_arbiter_pkg;

    localparam int P_DATA_WIDTH = 64;
    localparam int P_KEEP_WIDTH = 8;
    localparam int P_USER_WIDTH = 1;
    localparam int P_ID_WIDTH   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // One merged output beat; id carries the source port index.
    typedef struct packed {
        logic [P_DATA_WIDTH-1:0] data;
        logic [P_KEEP_WIDTH-1:0] keep;
        logic                    last;
        logic [P_ID_WIDTH-1:0]   id;
        logic [P_USER_WIDTH-1:0] user;
    } axis_beat_t;

endpackage

// File: rtl/axis_frame_rr_arbiter_if.sv
// Bundle of the requester-side (s_axis_*, one slice per port) and the
// merged sink-side (m_axis_*) stream signals of the arbiter.
interface axis_frame_rr_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [NUM_PORTS-1:0]            s_axis_tvalid;
    logic [NUM_PORTS-1:0]            s_axis_tready;
    logic [NUM_PORTS-1:0]            s_axis_tlast;
    logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser;

    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
    logic                            m_axis_tvalid;
    logic                            m_axis_tready;
    logic                            m_axis_tlast;
    logic [ID_WIDTH-1:0]             m_axis_tid;
    logic [USER_WIDTH-1:0]           m_axis_tuser;

    // Arbiter view: consumes the requester streams, drives the merged stream.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
        input  m_axis_tready
    );

    // Environment view: drives the requesters, receives the merged stream.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: registered outputs, full throughput, and the
// output held stable while stalled. Payload type is a parameter so the
// slice can be reused for any beat record.
module axis_skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);
    logic out_valid_q, skid_valid_q;
    T     out_q, skid_q;

    // Ready depends only on state, so upstream sees no comb path from out_ready.
    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

    // Output register refills from skid first; skid catches a beat during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_valid_i;
                if (in_valid_i) out_q <= in_data_i;
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_q       <= in_data_i;
            skid_valid_q <= 1'b1;
        end
    end
endmodule

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-granular round-robin merge of NUM_PORTS AXI-stream requesters into
// one sink. A grant lasts a whole frame; oversize frames are cut at
// MAX_BEATS, flagged bad in tuser, and the remainder is drained silently.
module axis_frame_rr_arbiter
    import axis_frame_rr_arbiter_pkg::*;
#(
    parameter int                    NUM_PORTS      = 4,
    parameter int                    DATA_WIDTH     = P_DATA_WIDTH,
    parameter int                    KEEP_WIDTH     = P_KEEP_WIDTH,
    parameter int                    USER_WIDTH     = P_USER_WIDTH,
    parameter int                    ID_WIDTH       = P_ID_WIDTH,
    parameter int                    MAX_BEATS      = 1024,
    parameter logic [USER_WIDTH-1:0] USER_BAD_VALUE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axis_frame_rr_arbiter_if.slave   axis,
    output logic                     grant_active,
    output logic [ID_WIDTH-1:0]      grant_idx,
    output logic                     truncated_pulse
);
    // Counter never exceeds MAX_BEATS; keep one bit when truncation is off.
    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d, ptr_q, ptr_d, pick;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                trunc_q, trunc_d;
    logic                g_valid, g_last;
    logic                in_valid, in_ready, out_valid;
    axis_beat_t          in_beat, out_beat;

    assign g_valid = axis.s_axis_tvalid[grant_q];
    assign g_last  = axis.s_axis_tlast[grant_q];

    // Rotating priority: first valid port after the last-served pointer.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(ptr_q) + k) % NUM_PORTS;
            if (!found && axis.s_axis_tvalid[idx]) begin
                pick  = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end

    // FSM next state, input mux, per-port ready and truncation marking.
    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        ptr_d              = ptr_q;
        cnt_d              = cnt_q;
        trunc_d            = 1'b0;
        in_valid           = 1'b0;
        axis.s_axis_tready = '0;
        in_beat.data       = axis.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        in_beat.keep       = axis.s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
        in_beat.last       = g_last;
        in_beat.id         = grant_q;
        in_beat.user       = axis.s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|axis.s_axis_tvalid) begin
                    grant_d = pick;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                axis.s_axis_tready[grant_q] = in_ready;
                in_valid                    = g_valid;
                if (g_valid && in_ready) begin
                    if (MAX_BEATS != 0) cnt_d = cnt_q + CNT_W'(1);
                    if (g_last) begin
                        ptr_d   = grant_q;
                        state_d = ST_IDLE;
                    end else if (MAX_BEATS != 0 && cnt_q == CNT_W'(MAX_BEATS - 1)) begin
                        // Close the frame here and poison it so a frame FIFO drops it.
                        in_beat.last = 1'b1;
                        in_beat.user = in_beat.user | USER_BAD_VALUE;
                        trunc_d      = 1'b1;
                        state_d      = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                axis.s_axis_tready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant, pointer, counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= ID_WIDTH'(NUM_PORTS - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    axis_skid_buffer #(.T(axis_beat_t)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_beat),
        .out_valid_o (out_valid),
        .out_ready_i (axis.m_axis_tready),
        .out_data_o  (out_beat)
    );

    assign axis.m_axis_tvalid = out_valid;
    assign axis.m_axis_tdata  = out_beat.data;
    assign axis.m_axis_tkeep  = out_beat.keep;
    assign axis.m_axis_tlast  = out_beat.last;
    assign axis.m_axis_tid    = out_beat.id;
    assign axis.m_axis_tuser  = out_beat.user;
    assign grant_active       = (state_q != ST_IDLE);
    assign grant_idx          = grant_q;
    assign truncated_pulse    = trunc_q;
endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Directed bench for the frame round-robin arbiter: per-port source queues,
// per-port expected-beat scoreboard, and ordering/latency checks on a log.
module tb_axis_frame_rr_arbiter;
    import axis_frame_rr_arbiter_pkg::*;

    localparam int NP = 4, DW = 64, KW = 8, UW = 1, IW = 2, MB = 8;

    logic            clk, rst_n;
    logic            grant_active, truncated_pulse;
    logic [IW-1:0]   grant_idx;

    axis_frame_rr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                               .USER_WIDTH(UW), .ID_WIDTH(IW)) axis ();

    axis_frame_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                            .ID_WIDTH(IW), .MAX_BEATS(MB), .USER_BAD_VALUE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .axis(axis),
        .grant_active(grant_active), .grant_idx(grant_idx), .truncated_pulse(truncated_pulse));

    typedef struct { axis_beat_t b; int gap; } src_t;

    src_t       src_q[NP][$];
    axis_beat_t exp_q[NP][$];
    int comps = 0, fails = 0, cyc = 0, frame_no = 0;
    int out_tid[$], out_cyc[$], out_last[$];
    int last_cnt = 0, trunc_cnt = 0, drive_cyc = -1;
    logic rand_ready = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        comps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a frame on port p; expected output is truncated to MB beats with a bad last.
    task automatic send_frame(input int p, input int n, input int gap_at = -1, input int gap_len = 0);
        src_t s;
        axis_beat_t e;
        for (int i = 0; i < n; i++) begin
            s.b.data = (64'(p) << 56) | (64'(frame_no) << 32) | 64'(i);
            s.b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
            s.b.last = (i == n - 1);
            s.b.id   = '0;
            s.b.user = '0;
            s.gap    = (i == gap_at) ? gap_len : 0;
            src_q[p].push_back(s);
            if (i < MB) begin
                e    = s.b;
                e.id = IW'(p);
                if (n > MB && i == MB - 1) begin
                    e.last = 1'b1;
                    e.user = 1'b1;
                end
                exp_q[p].push_back(e);
            end
        end
        frame_no++;
    endtask

    task automatic clear_log();
        out_tid.delete(); out_cyc.delete(); out_last.delete();
        last_cnt = 0; trunc_cnt = 0; drive_cyc = -1;
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = all_empty() && !axis.m_axis_tvalid && !grant_active;
        end
        comps++;
        assert (done) else begin
            fails++;
            $error("FAIL %s observed=busy expected=idle", tag);
        end
    endtask

    task automatic check_tids(input string tag, input int exp[$]);
        check({tag, "_len"}, out_tid.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_tid.size(); i++)
            check({tag, "_tid"}, out_tid[i], exp[i]);
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Source/sink driver: handshakes judged at negedge, inputs updated 1ns after posedge.
    initial begin
        logic [NP-1:0] fire;
        int  wleft[NP];
        bit  loaded[NP];
        axis.s_axis_tvalid = '0; axis.s_axis_tdata = '0; axis.s_axis_tkeep = '0;
        axis.s_axis_tlast  = '0; axis.s_axis_tuser = '0; axis.m_axis_tready = 1'b0;
        for (int p = 0; p < NP; p++) begin wleft[p] = 0; loaded[p] = 1'b0; end
        forever begin
            @(negedge clk);
            fire = axis.s_axis_tvalid & axis.s_axis_tready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                axis.s_axis_tvalid = '0;
                axis.m_axis_tready = 1'b0;
                for (int p = 0; p < NP; p++) loaded[p] = 1'b0;
                continue;
            end
            axis.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (fire[p] && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                    loaded[p] = 1'b0;
                end
                axis.s_axis_tvalid[p] = 1'b0;
                if (src_q[p].size() > 0) begin
                    if (!loaded[p]) begin wleft[p] = src_q[p][0].gap; loaded[p] = 1'b1; end
                    if (wleft[p] > 0) wleft[p]--;
                    else begin
                        axis.s_axis_tvalid[p]           = 1'b1;
                        axis.s_axis_tdata[p*DW +: DW]   = src_q[p][0].b.data;
                        axis.s_axis_tkeep[p*KW +: KW]   = src_q[p][0].b.keep;
                        axis.s_axis_tlast[p]            = src_q[p][0].b.last;
                        axis.s_axis_tuser[p*UW +: UW]   = src_q[p][0].b.user;
                        if (drive_cyc < 0) drive_cyc = cyc;
                    end
                end
            end
        end
    end

    // Output monitor: AXIS hold rule, scoreboard pop, ordering log.
    initial begin
        axis_beat_t got, prev;
        logic prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev_stall = 1'b0; continue; end
            got.data = axis.m_axis_tdata; got.keep = axis.m_axis_tkeep; got.last = axis.m_axis_tlast;
            got.id   = axis.m_axis_tid;   got.user = axis.m_axis_tuser;
            if (prev_stall) begin
                check("hold_valid", axis.m_axis_tvalid, 1'b1);
                check("hold_beat", got, prev);
            end
            if (truncated_pulse) trunc_cnt++;
            if (axis.m_axis_tvalid && axis.m_axis_tready) begin
                out_tid.push_back(int'(got.id));
                out_cyc.push_back(cyc);
                out_last.push_back(int'(got.last));
                if (got.last) last_cnt++;
                comps++;
                assert (exp_q[got.id].size() > 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected observed=tid%0d:%0h expected=no beat", got.id, got.data);
                end
                if (exp_q[got.id].size() > 0) check("sb_beat", got, exp_q[got.id].pop_front());
            end
            prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
            prev       = got;
        end
    end

    initial begin
        int order[$];
        int t3_rdy, gchg;
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", axis.m_axis_tvalid, 1'b0);
        check("rst_m_data", axis.m_axis_tdata, 64'h0);
        check("rst_m_last", axis.m_axis_tlast, 1'b0);
        check("rst_m_tid", axis.m_axis_tid, 2'd0);
        check("rst_s_tready", axis.s_axis_tready, 4'h0);
        check("rst_grant_active", grant_active, 1'b0);
        check("rst_grant_idx", grant_idx, 2'd0);
        check("rst_trunc", truncated_pulse, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two simultaneous 3-beat frames: port 0 first, one-cycle bubble, 2-cycle latency.
        clear_log();
        send_frame(0, 3); send_frame(2, 3);
        wait_idle("t1_idle", 100);
        check_tids("t1", '{0, 0, 0, 2, 2, 2});
        check("t1_latency", out_cyc[0], drive_cyc + 2);
        check("t1_stream", out_cyc[2] - out_cyc[0], 2);
        check("t1_bubble", out_cyc[3] - out_cyc[2], 2);
        check("t1_lasts", last_cnt, 2);

        // All ports busy with 2-beat frames: strict rotation 0..3.
        reset_pulse();
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) send_frame(p, 2);
        wait_idle("t2_idle", 300);
        order.delete();
        for (int i = 0; i < out_tid.size(); i++) if (out_last[i] != 0) order.push_back(out_tid[i]);
        out_tid = order;
        check_tids("t2_order", '{0, 1, 2, 3, 0, 1, 2, 3});
        check("t2_lasts", last_cnt, 8);

        // Oversize frame truncated at MB beats, remainder drained, next frame clean.
        clear_log();
        send_frame(1, MB + 2); send_frame(1, 2);
        wait_idle("t3_idle", 200);
        check("t3_beats", out_tid.size(), MB + 2);
        check("t3_cut_last", out_last[MB-1], 1);
        check("t3_pulses", trunc_cnt, 1);
        check("t3_lasts", last_cnt, 2);

        // Exactly-MB frame under random back-pressure: untouched, ordered, held.
        clear_log();
        rand_ready = 1'b1;
        send_frame(3, MB);
        wait_idle("t4_idle", 400);
        rand_ready = 1'b0;
        check("t4_beats", out_tid.size(), MB);
        check("t4_last", out_last[MB-1], 1);
        check("t4_pulses", trunc_cnt, 0);

        // Reset mid-frame: outputs drop at once, port 0 wins first afterwards.
        clear_log();
        send_frame(0, 5);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (out_tid.size() >= 2);
        end
        check("t5_started", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_m_valid", axis.m_axis_tvalid, 1'b0);
        check("t5_m_data", axis.m_axis_tdata, 64'h0);
        check("t5_s_tready", axis.s_axis_tready, 4'h0);
        check("t5_active", grant_active, 1'b0);
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send_frame(2, 2); send_frame(0, 2);
        wait_idle("t5_idle", 100);
        check_tids("t5", '{0, 0, 2, 2});

        // Granted port stalls 5 cycles mid-frame; port 3 must stay blocked.
        clear_log();
        send_frame(1, 4, 2, 5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = grant_active && (grant_idx == 2'd1);
        end
        check("t6_granted", seen, 1'b1);
        send_frame(3, 2);
        t3_rdy = 0; gchg = 0;
        for (int i = 0; i < 60 && exp_q[1].size() > 0; i++) begin
            @(negedge clk);
            if (axis.s_axis_tready[3]) t3_rdy++;
            if (grant_idx != 2'd1) gchg++;
        end
        check("t6_p3_ready", t3_rdy, 0);
        check("t6_grant_held", gchg, 0);
        wait_idle("t6_idle", 100);
        check_tids("t6", '{1, 1, 1, 1, 3, 3});
        check("t6_gap", out_cyc[2] - out_cyc[1], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end
endmodule
